dataload_sequencer: RTL and testbench
=====================================

# dataload_sequencer

Producer side of the PE-array load handshake. It accepts weight and input beats from an upstream valid/ready stream and writes them into the weight/input buffers. It raises `dataload_weight_valid` and `dataload_input_valid` when a full tile or row is resident. It also owns the `weight_number`, `input_load_number` and `layer_number` counters that the array controller branches on. It sits between the memory stream and the controller, advancing on the controller's per-weight consume pulse.

## Interface
- `DATA_W`, default 64: stream and buffer word width.
- `WEIGHT_BEATS`, default 2: beats per weight tile. Requires 8*WEIGHT_BEATS ≤ 16.
- `INPUT_BEATS`, default 2: beats per input row. Requires INPUT_BEATS ≤ 16.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dataload_en_i`  in  1  run enable; low aborts to IDLE.
- `src_data_i`  in  DATA_W  stream beat.
- `src_valid_i`  in  1  beat present.
- `src_ready_o`  out  1  beat accepted when `src_valid_i & src_ready_o`.
- `weight_advance_i`  in  1  one-cycle pulse: array consumed the current weight.
- `buf_wr_en_o`  out  1  buffer write strobe.
- `buf_wr_sel_o`  out  1  0 = weight buffer, 1 = input buffer.
- `buf_wr_addr_o`  out  4  word address.
- `buf_wr_data_o`  out  DATA_W  write data.
- `dataload_weight_valid`  out  1  current layer's 8 weight tiles resident.
- `dataload_input_valid`  out  1  current input row available.
- `weight_number`  out  3  weight index, 0-7.
- `input_load_number`  out  4  row index, 0-15.
- `layer_number`  out  3  layer index, 0-7.
- `done_o`  out  1  all 8 layers sequenced.

## Operation
- **Reset values:** all outputs 0; state IDLE.
- **States:** IDLE, LD_WEIGHT, LD_INPUT, COMPUTE, DONE.
- **IDLE:** `dataload_en_i` = 1 → LD_WEIGHT.
- **LD_WEIGHT:**
  - Accepts 8*WEIGHT_BEATS beats.
  - Address = tile*WEIGHT_BEATS + beat; sel = 0.
  - After the last beat: if layer 0 → LD_INPUT, else → COMPUTE.
  - Entering LD_WEIGHT clears `dataload_weight_valid`.
- **LD_INPUT:** layer 0 only. Accepts INPUT_BEATS beats; address = beat; sel = 1. After the last beat → COMPUTE.
- **COMPUTE:**
  - `src_ready_o` = 0.
  - Each `weight_advance_i` increments `weight_number`.
  - On advance with `weight_number` = 7:
    - `weight_number` → 0.
    - If row < 15: row++. Then → LD_INPUT for layer 0, or stay in COMPUTE for layers ≥ 1, whose inputs come from the array.
    - If row = 15: row → 0. If layer < 7: layer++ → LD_WEIGHT. If layer = 7 → DONE.
- **DONE:** `done_o` = 1; remains until `dataload_en_i` = 0, then → IDLE.
- **Ready rule:** `src_ready_o` = (state ∈ {LD_WEIGHT, LD_INPUT}) & `dataload_en_i`. It is combinational from state; no skid buffer.
- **`dataload_input_valid`:**
  - Layer 0: set with the last input beat's write; cleared by the advance that ends the row.
  - Layers ≥ 1: held at 1 throughout COMPUTE.
- **Abort:** `dataload_en_i` = 0 in any non-IDLE state → IDLE next cycle. All counters, valids and `done_o` clear. No beat is accepted in that cycle.
- **Ignored pulses:** `weight_advance_i` is ignored outside COMPUTE. A beat offered outside load states is not accepted and must be held by the source.

## Timing
- Beat accepted in cycle t → `buf_wr_*` valid in cycle t+1; all write outputs are registered.
- Valid flags rise in the same cycle as the write of the final beat, i.e. one cycle after its acceptance.
- State changes on the edge that accepts the final beat. With `src_valid_i` held high, back-to-back phases have zero bubbles.
- Counter updates are visible the cycle after the advance pulse.
- Asynchronous `rst_n` assertion mid-beat: the write strobe drops immediately and no partial tile is flagged valid.

## Structure
- **Package `dataload_pkg`:**
  - state enum `dl_state_e`.
  - constants N_WEIGHTS = 8, N_ROWS = 16, N_LAYERS = 8.
  - buffer-select constants SEL_WEIGHT = 0, SEL_INPUT = 1.
- **Sub-module `dataload_beat_cnt`:**
  - Loadable terminal-count beat counter; start/accept inputs, last-beat output.
  - Instantiated once and reused for both weight and input phases.

## Test plan
- **Layer-0 weight load:** `src_valid_i` held high with `dataload_en_i` raised → 16 writes, addresses 0-15, sel 0. `dataload_weight_valid` rises with write 15; state → LD_INPUT.
- **Stalled input row:** `src_valid_i` toggled 1,0,1 → exactly 2 input writes to addresses 0 and 1. `dataload_input_valid` rises 1 cycle after the 2nd accept.
- **Row advance:** 8 `weight_advance_i` pulses → `weight_number` 0..7 then 0, `input_load_number` 0→1. `dataload_input_valid` clears and a new LD_INPUT starts.
- **Layer roll:** row 15, weight 7, advance → layer 0→1, state LD_WEIGHT, `dataload_weight_valid` clears. After reload, `dataload_input_valid` = 1 with no input beats requested.
- **Full run:** 8 layers complete → `done_o` = 1. Then drop `dataload_en_i` → IDLE with all counters 0.
- **Abort and reset:** `dataload_en_i` dropped in LD_WEIGHT after beat 5 → no further writes, all outputs 0 next cycle. `rst_n` asserted mid-COMPUTE → outputs 0 immediately.

Source files
------------

// File: rtl/dataload_pkg.sv
// Shared types and constants for the PE-array load sequencer.
package dataload_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLdWeight,
    StLdInput,
    StCompute,
    StDone
  } dl_state_e;

  localparam int unsigned N_WEIGHTS = 8;
  localparam int unsigned N_ROWS    = 16;
  localparam int unsigned N_LAYERS  = 8;

  localparam logic SEL_WEIGHT = 1'b0;
  localparam logic SEL_INPUT  = 1'b1;

endpackage

// File: rtl/dataload_sequencer_if.sv
// Upstream beat stream plus weight/input buffer write port of the load sequencer.
interface dataload_sequencer_if #(
  parameter int unsigned DATA_W = 64
);
  logic [DATA_W-1:0] src_data_i;
  logic              src_valid_i;
  logic              src_ready_o;
  logic              buf_wr_en_o;
  logic              buf_wr_sel_o;
  logic [3:0]        buf_wr_addr_o;
  logic [DATA_W-1:0] buf_wr_data_o;

  // The sequencer side.
  modport master (
    input  src_data_i, src_valid_i,
    output src_ready_o, buf_wr_en_o, buf_wr_sel_o, buf_wr_addr_o, buf_wr_data_o
  );

  // The stream source / buffer side.
  modport slave (
    output src_data_i, src_valid_i,
    input  src_ready_o, buf_wr_en_o, buf_wr_sel_o, buf_wr_addr_o, buf_wr_data_o
  );
endinterface

// File: rtl/dataload_beat_cnt.sv
// Beat counter shared by the weight and input phases; wraps to zero on the terminal beat.
module dataload_beat_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_accept,
  input  logic [CNT_W-1:0] i_term,
  output logic [CNT_W-1:0] o_count,
  output logic             o_last
);

  logic [CNT_W-1:0] r_count;

  assign o_count = r_count;
  assign o_last  = i_accept && (r_count == i_term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_start || o_last) begin
      r_count <= '0;
    end else if (i_accept) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/dataload_sequencer.sv
// Loads weight tiles and input rows into the PE buffers and sequences weight/row/layer indices.
module dataload_sequencer
  import dataload_pkg::*;
#(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned WEIGHT_BEATS = 2,
  parameter int unsigned INPUT_BEATS  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dataload_en_i,
  input  logic                 weight_advance_i,
  dataload_sequencer_if.master bus,
  output logic                 dataload_weight_valid,
  output logic                 dataload_input_valid,
  output logic [2:0]           weight_number,
  output logic [3:0]           input_load_number,
  output logic [2:0]           layer_number,
  output logic                 done_o
);

  localparam logic [3:0] WtLast = 4'(N_WEIGHTS * WEIGHT_BEATS - 1);
  localparam logic [3:0] InLast = 4'(INPUT_BEATS - 1);

  dl_state_e         r_state;
  logic              r_wr_en, r_wr_sel, r_wv, r_iv, r_done;
  logic [3:0]        r_wr_addr, r_row;
  logic [DATA_W-1:0] r_wr_data;
  logic [2:0]        r_wn, r_layer;

  logic       w_load, w_accept, w_last;
  logic [3:0] w_term, w_count;

  assign w_load          = (r_state == StLdWeight) || (r_state == StLdInput);
  assign bus.src_ready_o = w_load & dataload_en_i;
  assign w_accept        = bus.src_valid_i & bus.src_ready_o;
  assign w_term          = (r_state == StLdWeight) ? WtLast : InLast;

  // Counter idles at zero outside load phases, so each phase starts at beat 0.
  dataload_beat_cnt #(
    .CNT_W (4)
  ) u_beat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (!w_load),
    .i_accept (w_accept),
    .i_term   (w_term),
    .o_count  (w_count),
    .o_last   (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || !dataload_en_i) begin
      r_state   <= StIdle;
      r_wr_en   <= 1'b0;
      r_wr_sel  <= SEL_WEIGHT;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wv      <= 1'b0;
      r_iv      <= 1'b0;
      r_wn      <= '0;
      r_row     <= '0;
      r_layer   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_sel  <= (r_state == StLdInput) ? SEL_INPUT : SEL_WEIGHT;
        r_wr_addr <= w_count;
        r_wr_data <= bus.src_data_i;
      end
      unique case (r_state)
        StIdle: begin
          r_state <= StLdWeight;
          r_wv    <= 1'b0;
        end
        StLdWeight: begin
          if (w_last) begin
            r_wv <= 1'b1;
            if (r_layer == '0) begin
              r_state <= StLdInput;
            end else begin
              // Deeper layers take their inputs from the array itself.
              r_state <= StCompute;
              r_iv    <= 1'b1;
            end
          end
        end
        StLdInput: begin
          if (w_last) begin
            r_iv    <= 1'b1;
            r_state <= StCompute;
          end
        end
        StCompute: begin
          if (weight_advance_i) begin
            if (r_wn != 3'(N_WEIGHTS - 1)) begin
              r_wn <= r_wn + 1'b1;
            end else begin
              r_wn <= '0;
              if (r_row != 4'(N_ROWS - 1)) begin
                r_row <= r_row + 1'b1;
                if (r_layer == '0) begin
                  r_iv    <= 1'b0;
                  r_state <= StLdInput;
                end
              end else begin
                r_row <= '0;
                r_iv  <= 1'b0;
                if (r_layer != 3'(N_LAYERS - 1)) begin
                  r_layer <= r_layer + 1'b1;
                  r_wv    <= 1'b0;
                  r_state <= StLdWeight;
                end else begin
                  r_done  <= 1'b1;
                  r_state <= StDone;
                end
              end
            end
          end
        end
        StDone: begin
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.buf_wr_en_o    = r_wr_en;
  assign bus.buf_wr_sel_o   = r_wr_sel;
  assign bus.buf_wr_addr_o  = r_wr_addr;
  assign bus.buf_wr_data_o  = r_wr_data;
  assign dataload_weight_valid = r_wv;
  assign dataload_input_valid  = r_iv;
  assign weight_number         = r_wn;
  assign input_load_number     = r_row;
  assign layer_number          = r_layer;
  assign done_o                = r_done;

endmodule

// File: tb/tb_dataload_sequencer.sv
// Randomized bench for dataload_sequencer against a phase-level reference model.
module tb_dataload_sequencer;
  localparam int unsigned DW = 64;
  localparam int unsigned WB = 2;
  localparam int unsigned IB = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       adv = 1'b0;
  logic       w_wv, w_iv, w_done;
  logic [2:0] w_wn, w_layer;
  logic [3:0] w_row;

  dataload_sequencer_if #(.DATA_W(DW)) bus ();

  dataload_sequencer #(
    .DATA_W       (DW),
    .WEIGHT_BEATS (WB),
    .INPUT_BEATS  (IB)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .dataload_en_i         (en),
    .weight_advance_i      (adv),
    .bus                   (bus),
    .dataload_weight_valid (w_wv),
    .dataload_input_valid  (w_iv),
    .weight_number         (w_wn),
    .input_load_number     (w_row),
    .layer_number          (w_layer),
    .done_o                (w_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: phase 0 idle, 1 weight load, 2 input load, 3 compute, 4 done.
  int ph, beat, wn, row, layer;
  bit wv, iv, dn, exp_wr, exp_sel;
  int exp_addr;
  logic [DW-1:0] exp_data;

  task automatic model_reset();
    ph = 0; beat = 0; wn = 0; row = 0; layer = 0;
    wv = 0; iv = 0; dn = 0; exp_wr = 0;
  endtask

  // One clock of stimulus; the model advances by the specified rules and all outputs are compared.
  task automatic cycle(input bit vin, input bit advin);
    bit mr, acc;
    logic [DW-1:0] d;
    logic [13:0] got_vec, exp_vec;
    d = {$urandom, $urandom};
    bus.src_valid_i = vin;
    bus.src_data_i  = d;
    adv = advin;
    #2;
    mr = en && (ph == 1 || ph == 2);
    n_checks++;
    if (bus.src_ready_o !== mr) begin
      n_fail++;
      $display("FAIL src_ready t=%0t got=%b exp=%b", $time, bus.src_ready_o, mr);
    end else n_pass++;
    acc = vin && mr;
    @(posedge clk); #1;
    exp_wr = acc;
    if (acc) begin
      exp_addr = beat;
      exp_sel  = (ph == 2);
      exp_data = d;
    end
    if (!en && ph != 0) begin
      model_reset();
    end else begin
      case (ph)
        0: if (en) begin ph = 1; wv = 0; end
        1: if (acc) begin
          beat++;
          if (beat == 8 * WB) begin
            beat = 0; wv = 1;
            if (layer == 0) ph = 2;
            else begin ph = 3; iv = 1; end
          end
        end
        2: if (acc) begin
          beat++;
          if (beat == IB) begin beat = 0; iv = 1; ph = 3; end
        end
        3: if (advin) begin
          if (wn < 7) wn++;
          else begin
            wn = 0;
            if (row < 15) begin
              row++;
              if (layer == 0) begin iv = 0; ph = 2; end
            end else begin
              row = 0; iv = 0;
              if (layer < 7) begin layer++; ph = 1; wv = 0; end
              else begin ph = 4; dn = 1; end
            end
          end
        end
        default: ;
      endcase
    end
    got_vec = {bus.buf_wr_en_o, w_wv, w_iv, w_wn, w_row, w_layer, w_done};
    exp_vec = {exp_wr, wv, iv, 3'(wn), 4'(row), 3'(layer), dn};
    n_checks++;
    if (got_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL outputs t=%0t got=%h exp=%h", $time, got_vec, exp_vec);
    end else n_pass++;
    if (exp_wr) begin
      n_checks++;
      if ({bus.buf_wr_sel_o, bus.buf_wr_addr_o, bus.buf_wr_data_o} !==
          {exp_sel, 4'(exp_addr), exp_data}) begin
        n_fail++;
        $display("FAIL write t=%0t got sel=%b addr=%0d data=%h exp sel=%b addr=%0d data=%h",
                 $time, bus.buf_wr_sel_o, bus.buf_wr_addr_o, bus.buf_wr_data_o,
                 exp_sel, exp_addr, exp_data);
      end else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; adv = 1'b0;
    bus.src_valid_i = 1'b0; bus.src_data_i = '0;
    #12;
    n_checks++;
    if ({bus.src_ready_o, bus.buf_wr_en_o, w_wv, w_iv, w_wn, w_row, w_layer, w_done} !== 15'd0)
    begin
      n_fail++;
      $display("FAIL reset_state got=%b exp=0",
               {bus.src_ready_o, bus.buf_wr_en_o, w_wv, w_iv, w_wn, w_row, w_layer, w_done});
    end else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_weight_load();
    int n_wr = 0;
    en = 1'b1;
    for (int i = 0; i < 40 && ph != 2; i++) begin
      cycle(1'b1, 1'b0);
      if (exp_wr) n_wr++;
    end
    n_checks++;
    if (ph != 2 || n_wr != 16 || w_wv !== 1'b1) begin
      n_fail++;
      $display("FAIL weight_load writes=%0d wv=%b exp writes=16 wv=1 ph=2 got ph=%0d",
               n_wr, w_wv, ph);
    end else n_pass++;
  endtask

  task automatic test_stalled_input();
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    n_checks++;
    if (w_iv !== 1'b0) begin
      n_fail++;
      $display("FAIL input_valid_early got=%b exp=0", w_iv);
    end else n_pass++;
    cycle(1'b1, 1'b0);
    n_checks++;
    if (w_iv !== 1'b1 || bus.buf_wr_addr_o !== 4'd1 || bus.buf_wr_sel_o !== 1'b1) begin
      n_fail++;
      $display("FAIL input_row got iv=%b addr=%0d sel=%b exp iv=1 addr=1 sel=1",
               w_iv, bus.buf_wr_addr_o, bus.buf_wr_sel_o);
    end else n_pass++;
  endtask

  task automatic test_row_advance();
    for (int i = 0; i < 8; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'b1);
      n_checks++;
      if (w_wn !== 3'((i + 1) % 8)) begin
        n_fail++;
        $display("FAIL weight_number got=%0d exp=%0d", w_wn, (i + 1) % 8);
      end else n_pass++;
    end
    n_checks++;
    if (w_row !== 4'd1 || w_iv !== 1'b0 || bus.src_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL row_advance got row=%0d iv=%b ready=%b exp row=1 iv=0 ready=1",
               w_row, w_iv, bus.src_ready_o);
    end else n_pass++;
  endtask

  task automatic test_full_run();
    int guard = 0;
    while (ph != 4 && guard < 20000) begin
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      guard++;
    end
    n_checks++;
    if (ph != 4 || w_done !== 1'b1) begin
      n_fail++;
      $display("FAIL full_run got done=%b after %0d cycles exp done=1", w_done, guard);
    end else n_pass++;
    en = 1'b0;
    cycle(1'b1, 1'b0);
    n_checks++;
    if ({w_wn, w_row, w_layer, w_done, w_wv, w_iv} !== 13'd0) begin
      n_fail++;
      $display("FAIL done_exit got=%b exp=0", {w_wn, w_row, w_layer, w_done, w_wv, w_iv});
    end else n_pass++;
  endtask

  task automatic test_abort();
    int guard = 0;
    en = 1'b1;
    cycle(1'b0, 1'b0);
    while (beat < 5 && guard < 40) begin
      cycle(1'b1, 1'b0);
      guard++;
    end
    en = 1'b0;
    cycle(1'b1, 1'b0);
    n_checks++;
    if ({bus.buf_wr_en_o, bus.buf_wr_addr_o, w_wv, w_iv, w_wn, w_row, w_layer, w_done}
        !== 18'd0) begin
      n_fail++;
      $display("FAIL abort got=%b exp=0",
               {bus.buf_wr_en_o, bus.buf_wr_addr_o, w_wv, w_iv, w_wn, w_row, w_layer, w_done});
    end else n_pass++;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
  endtask

  task automatic test_async_reset();
    int guard = 0;
    en = 1'b1;
    while ((ph != 3 || wn < 3) && guard < 200) begin
      cycle(1'b1, ph == 3);
      guard++;
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.src_ready_o, bus.buf_wr_en_o, w_wv, w_iv, w_wn, w_row, w_layer, w_done} !== 15'd0)
    begin
      n_fail++;
      $display("FAIL async_reset got=%b exp=0 (wn before=%0d)",
               {bus.src_ready_o, bus.buf_wr_en_o, w_wv, w_iv, w_wn, w_row, w_layer, w_done}, wn);
    end else n_pass++;
    en = 1'b0;
    model_reset();
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    en = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_weight_load();
    test_stalled_input();
    test_row_advance();
    test_full_run();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
